mimo_load_sequencer: RTL

- Front-end controller for the 3-antenna MIMO-OFDM receiver top.
- Takes one upstream sample stream over a valid/ready handshake and plays it into the receiver in a fixed order:
  - 32 equalizer weights, then 64 long-preamble samples, then 18 channel (H) words, then the payload.
- Drives the receiver's weight_valid / preamble_valid / H_valid / input_valid strobes, the shared signal buses and weight_addr.
- Counts receiver output_valid beats to detect frame completion or a stall.

---
 rtl/mimo_pkg.sv | 22 ++
 rtl/mimo_out_watchdog.sv | 36 +++
 rtl/mimo_load_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/mimo_pkg.sv
// mimo_pkg: shared state encoding and frame-layout constants for the MIMO load sequencer
package mimo_pkg;
  localparam int DATA_WIDTH = 13;
  localparam int N_WEIGHT = 32;
  localparam int N_PREAMBLE = 64;
  localparam int N_ANT = 3;
  localparam int H_PER_ANT = 3;
  // H words arrive as H0..H2 real parts (3 each), then H0..H2 imaginary parts
  localparam int N_H = 2 * N_ANT * H_PER_ANT;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_W   = 3'd1,
    LOAD_P   = 3'd2,
    LOAD_H   = 3'd3,
    RUN      = 3'd4,
    WAIT_OUT = 3'd5,
    DONE     = 3'd6
  } state_t;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/mimo_out_watchdog.sv
// mimo_out_watchdog: counts receiver output beats, times out idle waits, holds the sticky error
module mimo_out_watchdog #(
  parameter int OUT_COUNT = 128,
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_start,
  input  logic i_en,
  input  logic i_wait,
  input  logic i_out_valid,
  output logic o_reached,
  output logic o_timeout,
  output logic o_error
);
  localparam int OW = $clog2(OUT_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [OW-1:0] r_out_cnt;
  logic [TW-1:0] r_to_cnt;
  logic r_error;
  assign o_reached = r_out_cnt == OW'(OUT_COUNT);
  assign o_timeout = r_to_cnt == TW'(TIMEOUT);
  assign o_error = r_error;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_cnt <= '0;
      r_to_cnt <= '0;
      r_error <= 1'b0;
    end else begin
      r_out_cnt <= i_clr ? '0 : (i_en && i_out_valid && !o_reached) ? r_out_cnt + 1'b1 : r_out_cnt;
      r_to_cnt <= (i_clr || !i_wait || i_out_valid) ? '0 : o_timeout ? r_to_cnt : r_to_cnt + 1'b1;
      r_error <= i_start ? 1'b0 : (i_wait && o_timeout && !o_reached) ? 1'b1 : r_error;
    end
  end
endmodule

// File: rtl/mimo_load_sequencer.sv
// mimo_load_sequencer: plays one upstream stream into the MIMO receiver as weights, preamble, H, payload
module mimo_load_sequencer
  import mimo_pkg::*;
#(
  parameter int DATA_LEN = 500,
  parameter int OUT_COUNT = 128,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s0_real,
  input  logic [DATA_WIDTH-1:0] s0_imag,
  input  logic [DATA_WIDTH-1:0] s1_real,
  input  logic [DATA_WIDTH-1:0] s1_imag,
  input  logic [DATA_WIDTH-1:0] s2_real,
  input  logic [DATA_WIDTH-1:0] s2_imag,
  output logic                  weight_valid,
  output logic                  preamble_valid,
  output logic                  H_valid,
  output logic                  input_valid,
  output logic [4:0]            weight_addr,
  output logic [DATA_WIDTH-1:0] signal0_real,
  output logic [DATA_WIDTH-1:0] signal0_imag,
  output logic [DATA_WIDTH-1:0] signal1_real,
  output logic [DATA_WIDTH-1:0] signal1_imag,
  output logic [DATA_WIDTH-1:0] signal2_real,
  output logic [DATA_WIDTH-1:0] signal2_imag,
  input  logic                  rx_output_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            phase
);
  localparam int BW = $clog2(max2(max2(N_WEIGHT, N_PREAMBLE), max2(N_H, DATA_LEN)));
  state_t r_state, w_next;
  logic [BW-1:0] r_cnt, w_len_m1;
  logic w_acc, w_start, w_last, w_reached, w_timeout;
  assign s_ready = !abort && (r_state inside {LOAD_W, LOAD_P, LOAD_H, RUN});
  assign w_acc = s_valid && s_ready;
  assign w_start = start && !abort && r_state == IDLE;
  assign w_len_m1 = r_state == LOAD_W ? BW'(N_WEIGHT - 1) :
                    r_state == LOAD_P ? BW'(N_PREAMBLE - 1) :
                    r_state == LOAD_H ? BW'(N_H - 1) : BW'(DATA_LEN - 1);
  // terminal beat and phase change share one edge, so the next phase starts without a bubble
  assign w_last = w_acc && r_cnt == w_len_m1;
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign phase = r_state;
  always_comb begin
    w_next = r_state;
    if (abort) w_next = IDLE;
    else case (r_state)
      IDLE:     w_next = start ? LOAD_W : IDLE;
      LOAD_W:   w_next = w_last ? LOAD_P : LOAD_W;
      LOAD_P:   w_next = w_last ? LOAD_H : LOAD_P;
      LOAD_H:   w_next = w_last ? RUN : LOAD_H;
      RUN:      w_next = w_last ? WAIT_OUT : RUN;
      WAIT_OUT: w_next = w_reached ? DONE : w_timeout ? IDLE : WAIT_OUT;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      weight_valid <= 1'b0;
      preamble_valid <= 1'b0;
      H_valid <= 1'b0;
      input_valid <= 1'b0;
      weight_addr <= '0;
      signal0_real <= '0;
      signal0_imag <= '0;
      signal1_real <= '0;
      signal1_imag <= '0;
      signal2_real <= '0;
      signal2_imag <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (abort || w_start || w_last) ? '0 : w_acc ? r_cnt + 1'b1 : r_cnt;
      weight_valid <= w_acc && r_state == LOAD_W;
      preamble_valid <= w_acc && r_state == LOAD_P;
      H_valid <= w_acc && r_state == LOAD_H;
      input_valid <= w_acc && r_state == RUN;
      if (w_acc && r_state == LOAD_W) weight_addr <= r_cnt[4:0];
      if (w_acc) signal0_real <= s0_real;
      if (w_acc && r_state != LOAD_H) signal0_imag <= s0_imag;
      if (w_acc && r_state == RUN) begin
        signal1_real <= s1_real;
        signal1_imag <= s1_imag;
        signal2_real <= s2_real;
        signal2_imag <= s2_imag;
      end
    end
  end
  mimo_out_watchdog #(.OUT_COUNT(OUT_COUNT), .TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .rst_n(rst_n),
    .i_clr(abort || w_start),
    .i_start(w_start),
    .i_en(r_state != IDLE),
    .i_wait(r_state == WAIT_OUT && !abort),
    .i_out_valid(rx_output_valid),
    .o_reached(w_reached),
    .o_timeout(w_timeout),
    .o_error(error)
  );
endmodule
